memory_ram_writer: RTL and testbench

//   Writable counterpart of the CGRA's read-only coefficient memories. Accepts a

---
 rtl/cgra_mem_pkg.sv | 13 +
 rtl/memory_ram_writer_if.sv | 25 ++
 rtl/memory_ram_dp.sv | 29 ++
 rtl/memory_ram_writer.sv | 94 +++++++++
 tb/tb_memory_ram_writer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cgra_mem_pkg.sv
// Shared definitions for the CGRA coefficient memories: FSM encoding of the
// writable RAM loader and the read latency common to all memory variants.
package cgra_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MEM_RD_LATENCY = 1;

endpackage

// File: rtl/memory_ram_writer_if.sv
// Write-stream and read-port bundle of memory_ram_writer; the read side
// matches the ROM read port so consumers can swap memories unchanged.
interface memory_ram_writer_if #(
  parameter int data_depth = 5,
  parameter int data_width = 5
) ();

  logic                         in_valid;
  logic signed [data_width-1:0] in_data;
  logic                         in_ready;
  logic                         read;
  logic [data_depth-1:0]        addr;
  logic signed [data_width-1:0] data;

  modport master (
    output in_valid, in_data, read, addr,
    input  in_ready, data
  );

  modport slave (
    input  in_valid, in_data, read, addr,
    output in_ready, data
  );

endinterface

// File: rtl/memory_ram_dp.sv
// Simple dual-port array: one write port, one registered read-first read port.
// The array itself is never reset; only the read register is.
module memory_ram_dp #(
  parameter int data_depth = 5,
  parameter int data_width = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [data_depth-1:0]        waddr,
  input  logic signed [data_width-1:0] wdata,
  input  logic                         re,
  input  logic [data_depth-1:0]        raddr,
  output logic signed [data_width-1:0] rdata
);

  logic signed [data_width-1:0] mem [2**data_depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking update of mem gives read-first on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/memory_ram_writer.sv
// Burst loader for a writable coefficient memory: after start, streams words
// into consecutive (wrapping) addresses from base_addr; read port is always live.
module memory_ram_writer
  import cgra_mem_pkg::*;
#(
  parameter int data_depth = 5,
  parameter int data_width = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [data_depth-1:0] base_addr,
  input  logic [data_depth:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [data_depth:0]   words_written,
  memory_ram_writer_if.slave    bus
);

  localparam logic [data_depth-1:0] PTR_ONE = 1;
  localparam logic [data_depth:0]   CNT_ONE = 1;

  state_t                state;
  state_t                state_next;
  logic                  in_ready;
  logic                  accept;
  logic                  launch;
  logic [data_depth-1:0] wr_ptr;
  logic [data_depth:0]   remaining;

  assign accept       = bus.in_valid && (state == FILL);
  assign launch       = start && (state == IDLE);
  assign bus.in_ready = in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (length == '0) ? DONE : FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && remaining == CNT_ONE) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointer wraps naturally at 2**data_depth; start outside IDLE never reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      remaining     <= '0;
      words_written <= '0;
    end else if (launch) begin
      wr_ptr        <= base_addr;
      remaining     <= length;
      words_written <= '0;
    end else if (accept) begin
      wr_ptr        <= wr_ptr + PTR_ONE;
      remaining     <= remaining - CNT_ONE;
      words_written <= words_written + CNT_ONE;
    end
  end

  memory_ram_dp #(
    .data_depth (data_depth),
    .data_width (data_width)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (bus.in_data),
    .re    (bus.read),
    .raddr (bus.addr),
    .rdata (bus.data)
  );

endmodule

// File: tb/tb_memory_ram_writer.sv
// Randomized bench for memory_ram_writer against an array-based memory model.
module tb_memory_ram_writer;
  import cgra_mem_pkg::*;

  localparam int DD = 5;
  localparam int DW = 5;
  localparam int N  = 2**DD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DD-1:0] base_addr = '0;
  logic [DD:0]   length = '0;
  logic          busy;
  logic          done;
  logic [DD:0]   words_written;

  memory_ram_writer_if #(.data_depth(DD), .data_width(DW)) bus ();

  memory_ram_writer #(.data_depth(DD), .data_width(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ref_mem [N];
  bit ref_known [N];
  int valid_pat [$];
  int data_pat [$];

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic rd(input int a, output int v);
    @(negedge clk);
    bus.read = 1'b1;
    bus.addr = a[DD-1:0];
    repeat (MEM_RD_LATENCY) @(negedge clk);
    bus.read = 1'b0;
    v = int'(bus.data);
  endtask

  task automatic verify_mem(input string tag);
    int v;
    for (int i = 0; i < N; i++) begin
      if (ref_known[i]) begin
        rd(i, v);
        check($sformatf("%s_mem[%0d]", tag, i), v, ref_mem[i]);
      end
    end
  endtask

  // One complete burst; valid/data come from the pattern queues when loaded.
  task automatic burst(input int base, input int len, input int pct, input bit poke);
    int ptr;
    int acc;
    int budget;
    bit v;
    logic signed [DW-1:0] d;
    bit first;
    ptr = base % N;
    acc = 0;
    first = 1'b1;
    @(negedge clk);
    start     = 1'b1;
    base_addr = base[DD-1:0];
    length    = len[DD:0];
    @(negedge clk);
    start     = 1'b0;
    base_addr = DD'($urandom);
    length    = (DD+1)'($urandom);
    if (len == 0) begin
      check("zero_done", int'(done), 1);
      check("zero_ready", int'(bus.in_ready), 0);
    end else begin
      check("fill_busy", int'(busy), 1);
      budget = len * 20 + 40;
      while (acc < len && budget > 0) begin
        budget--;
        check("fill_ready", int'(bus.in_ready), 1);
        check("fill_done", int'(done), 0);
        check("fill_ww", int'(words_written), acc);
        if (valid_pat.size() > 0) v = (valid_pat.pop_front() != 0);
        else v = ($urandom_range(1, 100) <= pct);
        if (data_pat.size() > 0) d = DW'(data_pat.pop_front());
        else d = DW'($urandom);
        bus.in_valid = v;
        bus.in_data  = d;
        if (poke && first) begin
          start     = 1'b1;
          base_addr = 5'd20;
          length    = 6'd1;
        end
        first = 1'b0;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b0;
        if (v) begin
          ref_mem[ptr]   = int'(d);
          ref_known[ptr] = 1'b1;
          ptr = (ptr + 1) % N;
          acc++;
        end
      end
      check("burst_accepts", acc, len);
      check("done_pulse", int'(done), 1);
      check("done_ready", int'(bus.in_ready), 0);
    end
    check("ww_final", int'(words_written), len);
    check("done_busy", int'(busy), 1);
    @(negedge clk);
    check("done_clear", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_ready", int'(bus.in_ready), 0);
  endtask

  initial begin
    int v;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.read     = 1'b1;
    bus.addr     = '0;
    for (int i = 0; i < N; i++) begin
      ref_mem[i]   = 0;
      ref_known[i] = 1'b0;
    end

    // Reset behaviour with a read pending
    repeat (3) @(negedge clk);
    check("rst_data", int'(bus.data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(bus.in_ready), 0);
    check("rst_ww", int'(words_written), 0);
    bus.read = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);

    // Basic burst with valid held high
    data_pat = '{1, -2, 3, -4};
    burst(3, 4, 100, 1'b0);
    rd(4, v);
    check("addr4", v, -2);
    verify_mem("basic");

    // Wrap-around, then a zero-length burst
    burst(30, 4, 100, 1'b0);
    verify_mem("wrap");
    burst(9, 0, 100, 1'b0);
    verify_mem("zero");

    // Valid gaps
    valid_pat = '{1, 0, 0, 1, 1};
    burst(16, 3, 100, 1'b0);
    verify_mem("gaps");

    // Start pulsed during FILL must be ignored
    burst(10, 3, 50, 1'b1);
    verify_mem("poke");

    // Read-first collision on address 7
    data_pat = '{5};
    burst(7, 1, 100, 1'b0);
    @(negedge clk);
    start     = 1'b1;
    base_addr = 5'd7;
    length    = 6'd1;
    @(negedge clk);
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 5'sd9;
    bus.read     = 1'b1;
    bus.addr     = 5'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.read     = 1'b0;
    ref_mem[7]   = 9;
    check("rf_old", int'(bus.data), 5);
    check("rf_done", int'(done), 1);
    rd(7, v);
    check("rf_new", v, 9);

    // Full-array burst and random bursts
    burst(5, N, 80, 1'b0);
    verify_mem("full");
    for (int k = 0; k < 6; k++) begin
      burst($urandom_range(0, N - 1), $urandom_range(0, N), $urandom_range(30, 100), 1'b0);
    end
    verify_mem("rand");

    // Reset mid-burst after two of five words
    @(negedge clk);
    start     = 1'b1;
    base_addr = 5'd12;
    length    = 6'd5;
    @(negedge clk);
    start = 1'b0;
    data_pat = '{-3, 6};
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(data_pat.pop_front());
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    ref_mem[12] = -3;
    ref_mem[13] = 6;
    ref_known[12] = 1'b1;
    ref_known[13] = 1'b1;
    check("abort_ww_before", int'(words_written), 2);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(bus.in_ready), 0);
    check("abort_done", int'(done), 0);
    check("abort_ww", int'(words_written), 0);
    check("abort_data", int'(bus.data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
      check("abort_idle", int'(busy), 0);
    end
    rd(12, v);
    check("abort_w0", v, -3);
    rd(13, v);
    check("abort_w1", v, 6);
    verify_mem("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
